// File: rtl/resp_out_fifo_if.sv
// Handshake bundle for the response output FIFO: producer push side, downstream
// valid/ready side and status. The slave modport is the FIFO's view of it.
interface resp_out_fifo_if #(
  parameter int ID_W   = 2,
  parameter int RESP_W = 2,
  parameter int DATA_W = 32
);
  logic              resp_push;
  logic [ID_W-1:0]   resp_in_id;
  logic [RESP_W-1:0] resp_in_code;
  logic [DATA_W-1:0] resp_in_data;
  logic              fifo_full;
  logic              fifo_almost_full;
  logic              out_valid;
  logic              out_ready;
  logic [ID_W-1:0]   out_id;
  logic [RESP_W-1:0] out_code;
  logic [DATA_W-1:0] out_data;
  logic              overflow_err;
  logic [15:0]       sent_count;

  modport master (
    output resp_push, resp_in_id, resp_in_code, resp_in_data, out_ready,
    input  fifo_full, fifo_almost_full, out_valid, out_id, out_code, out_data,
           overflow_err, sent_count
  );

  modport slave (
    input  resp_push, resp_in_id, resp_in_code, resp_in_data, out_ready,
    output fifo_full, fifo_almost_full, out_valid, out_id, out_code, out_data,
           overflow_err, sent_count
  );
endinterface

// File: rtl/resp_out_fifo.sv
// Response transmitter: DEPTH-entry circular FIFO feeding one registered
// valid/ready output stage, with bypass into an idle stage, overflow flag and delivery count.
module resp_out_fifo #(
  parameter int DEPTH  = 4,
  parameter int ID_W   = 2,
  parameter int RESP_W = 2,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_b,
  resp_out_fifo_if.slave bus
);

  localparam int              PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]  AFULL_CNT = (PTR_W + 1)'(DEPTH - 1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RESP_W-1:0] code;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Storage and output stage state
  entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  out_state_e       r_state;
  entry_t           r_out;
  logic             r_overflow_err;
  logic [15:0]      r_sent_count;

  // Per-cycle decisions
  out_state_e w_state_nxt;
  entry_t     w_in;
  entry_t     w_head;
  entry_t     w_load_entry;
  logic       w_out_valid;
  logic       w_handshake;
  logic       w_stage_free;
  logic       w_is_full;
  logic       w_pop;
  logic       w_bypass;
  logic       w_load;
  logic       w_push_accept;
  logic       w_drop;

  assign w_in         = '{id: bus.resp_in_id, code: bus.resp_in_code, data: bus.resp_in_data};
  assign w_head       = r_mem[r_rd_ptr];
  assign w_out_valid  = (r_state == OUT_VALID);
  assign w_handshake  = w_out_valid && bus.out_ready;
  assign w_stage_free = !w_out_valid || w_handshake;
  assign w_is_full    = (r_count == DEPTH_CNT);

  // The head only leaves memory when the stage can take it; an empty memory
  // lets a fresh push skip storage entirely.
  assign w_pop         = w_stage_free && (r_count != '0);
  assign w_bypass      = w_stage_free && (r_count == '0) && bus.resp_push;
  assign w_push_accept = bus.resp_push && !w_bypass && (!w_is_full || w_pop);
  assign w_drop        = bus.resp_push && w_is_full && !w_pop;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_entry = w_head;
    if (w_stage_free) begin
      if (w_pop) begin
        w_load       = 1'b1;
        w_load_entry = w_head;
        w_state_nxt  = OUT_VALID;
      end else if (w_bypass) begin
        w_load       = 1'b1;
        w_load_entry = w_in;
        w_state_nxt  = OUT_VALID;
      end else begin
        w_state_nxt  = OUT_EMPTY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= OUT_EMPTY;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_out <= w_load_entry;
    end
  end

  // NOTE: the memory is cleared on reset so no stale response can ever be
  // observed after a mid-operation reset; small DEPTH keeps this affordable.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_accept) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  // When full with a same-cycle pop, wr_ptr equals rd_ptr: the stage reads the
  // old head combinationally while the write lands in that slot at the edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)         r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_accept, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overflow_err <= 1'b0;
      r_sent_count   <= '0;
    end else begin
      r_overflow_err <= r_overflow_err | w_drop;
      if (w_handshake) r_sent_count <= r_sent_count + 16'd1;
    end
  end

  assign bus.out_valid        = w_out_valid;
  assign bus.out_id           = w_out_valid ? r_out.id   : '0;
  assign bus.out_code         = w_out_valid ? r_out.code : '0;
  assign bus.out_data         = w_out_valid ? r_out.data : '0;
  assign bus.fifo_full        = w_is_full;
  assign bus.fifo_almost_full = (r_count >= AFULL_CNT);
  assign bus.overflow_err     = r_overflow_err;
  assign bus.sent_count       = r_sent_count;

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_b)
    (w_out_valid && !bus.out_ready) |=> (w_out_valid && $stable(r_out)));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_b)
    r_count <= DEPTH_CNT);

endmodule

// File: tb/tb_resp_out_fifo.sv
// Directed bench for resp_out_fifo (DEPTH=4): a vector table for fill/overflow/drain,
// then hand-written sequences for full-with-pop, pointer wrap and mid-run reset.
module tb_resp_out_fifo;

  logic clk;
  logic rst_b;
  int   n_vec;
  int   n_err;

  resp_out_fifo_if #(.ID_W(2), .RESP_W(2), .DATA_W(32)) bus ();

  resp_out_fifo #(.DEPTH(4), .ID_W(2), .RESP_W(2), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [1:0]  id;
    logic [1:0]  code;
    logic [31:0] data;
    logic        ready;
    logic        e_valid;
    logic [1:0]  e_id;
    logic [1:0]  e_code;
    logic [31:0] e_data;
    logic        e_full;
    logic        e_afull;
    logic        e_ovf;
    logic [15:0] e_sent;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic push, input logic [1:0] id, input logic [1:0] code,
                      input logic [31:0] data, input logic ready);
    @(negedge clk);
    bus.resp_push    = push;
    bus.resp_in_id   = id;
    bus.resp_in_code = code;
    bus.resp_in_data = data;
    bus.out_ready    = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic valid, input logic [1:0] id,
                            input logic [1:0] code, input logic [31:0] data);
    check({name, ".valid"}, 32'(bus.out_valid), 32'(valid));
    check({name, ".id"},    32'(bus.out_id),    32'(id));
    check({name, ".code"},  32'(bus.out_code),  32'(code));
    check({name, ".data"},  bus.out_data,       data);
  endtask

  task automatic expect_zero_outputs(input string name);
    expect_out(name, 1'b0, 2'd0, 2'd0, 32'd0);
    check({name, ".full"},  32'(bus.fifo_full),        32'd0);
    check({name, ".afull"}, 32'(bus.fifo_almost_full), 32'd0);
    check({name, ".ovf"},   32'(bus.overflow_err),     32'd0);
    check({name, ".sent"},  32'(bus.sent_count),       32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    bus.resp_push    = 1'b0;
    bus.resp_in_id   = '0;
    bus.resp_in_code = '0;
    bus.resp_in_data = '0;
    bus.out_ready    = 1'b0;
    rst_b            = 1'b0;
    #1;
    expect_zero_outputs(name);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_b = 1'b1;
    bus.resp_push    = 1'b0;
    bus.resp_in_id   = '0;
    bus.resp_in_code = '0;
    bus.resp_in_data = '0;
    bus.out_ready    = 1'b0;

    // Expected values are the outputs right after the edge that consumes the row's inputs.
    // sent_count runs on from the single-response row into the drain rows.
    //          push  id    code  data          rdy   valid id    code  data          full  afull ovf   sent
    vecs[0]  = '{1'b1, 2'd1, 2'd0, 32'h0000_00AA, 1'b1, 1'b1, 2'd1, 2'd0, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b0, 16'd1};
    vecs[2]  = '{1'b1, 2'd0, 2'd1, 32'h100,       1'b0, 1'b1, 2'd0, 2'd1, 32'h100,       1'b0, 1'b0, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 2'd1, 2'd2, 32'h101,       1'b0, 1'b1, 2'd0, 2'd1, 32'h100,       1'b0, 1'b0, 1'b0, 16'd1};
    vecs[4]  = '{1'b1, 2'd2, 2'd3, 32'h102,       1'b0, 1'b1, 2'd0, 2'd1, 32'h100,       1'b0, 1'b0, 1'b0, 16'd1};
    vecs[5]  = '{1'b1, 2'd3, 2'd0, 32'h103,       1'b0, 1'b1, 2'd0, 2'd1, 32'h100,       1'b0, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 2'd0, 2'd1, 32'h104,       1'b0, 1'b1, 2'd0, 2'd1, 32'h100,       1'b1, 1'b1, 1'b0, 16'd1};
    vecs[7]  = '{1'b1, 2'd1, 2'd2, 32'h105,       1'b0, 1'b1, 2'd0, 2'd1, 32'h100,       1'b1, 1'b1, 1'b1, 16'd1};
    vecs[8]  = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 1'b1, 2'd0, 2'd1, 32'h100,       1'b1, 1'b1, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b1, 1'b1, 2'd1, 2'd2, 32'h101,       1'b0, 1'b1, 1'b1, 16'd2};
    vecs[10] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b1, 1'b1, 2'd2, 2'd3, 32'h102,       1'b0, 1'b0, 1'b1, 16'd3};
    vecs[11] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b1, 1'b1, 2'd3, 2'd0, 32'h103,       1'b0, 1'b0, 1'b1, 16'd4};
    vecs[12] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b1, 1'b1, 2'd0, 2'd1, 32'h104,       1'b0, 1'b0, 1'b1, 16'd5};
    vecs[13] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b1, 1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 16'd6};
    vecs[14] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 1'b0, 1'b1, 16'd6};

    do_reset("reset0");

    for (int v = 0; v < 15; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      step(vecs[v].push, vecs[v].id, vecs[v].code, vecs[v].data, vecs[v].ready);
      expect_out(tag, vecs[v].e_valid, vecs[v].e_id, vecs[v].e_code, vecs[v].e_data);
      check({tag, ".full"},  32'(bus.fifo_full),        32'(vecs[v].e_full));
      check({tag, ".afull"}, 32'(bus.fifo_almost_full), 32'(vecs[v].e_afull));
      check({tag, ".ovf"},   32'(bus.overflow_err),     32'(vecs[v].e_ovf));
      check({tag, ".sent"},  32'(bus.sent_count),       32'(vecs[v].e_sent));
    end

    // Full memory, push with a same-cycle pop: accepted, lands last, no overflow.
    do_reset("reset1");
    for (int i = 0; i < 5; i++) step(1'b1, 2'(i), 2'(i), 32'h200 + 32'(i), 1'b0);
    check("fullpop.pre_full", 32'(bus.fifo_full), 32'd1);
    expect_out("fullpop.pre", 1'b1, 2'd0, 2'd0, 32'h200);
    step(1'b1, 2'd1, 2'd1, 32'h205, 1'b1);
    check("fullpop.full", 32'(bus.fifo_full),    32'd1);
    check("fullpop.ovf",  32'(bus.overflow_err), 32'd0);
    expect_out("fullpop.head", 1'b1, 2'd1, 2'd1, 32'h201);
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
      expect_out($sformatf("fullpop.drain%0d", k), 1'b1, 2'(k), 2'(k), 32'h200 + 32'(k));
    end
    step(1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    expect_out("fullpop.empty", 1'b0, 2'd0, 2'd0, 32'h0);
    check("fullpop.sent", 32'(bus.sent_count),   32'd6);
    check("fullpop.ovf2", 32'(bus.overflow_err), 32'd0);

    // Streaming with one entry held in memory so both pointers advance every cycle and wrap.
    do_reset("reset2");
    step(1'b1, 2'd0, 2'd0, 32'h300, 1'b0);
    step(1'b1, 2'd1, 2'd1, 32'h301, 1'b0);
    for (int k = 2; k < 22; k++) begin
      step(1'b1, 2'(k), 2'(k), 32'h300 + 32'(k), 1'b1);
      expect_out($sformatf("stream%0d", k), 1'b1, 2'(k - 1), 2'(k - 1), 32'h300 + 32'(k - 1));
    end
    step(1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    expect_out("stream.last", 1'b1, 2'd1, 2'd1, 32'h315);
    step(1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    expect_out("stream.empty", 1'b0, 2'd0, 2'd0, 32'h0);
    check("stream.sent", 32'(bus.sent_count), 32'd22);

    // Reset mid-operation with a staged response and three queued behind it.
    do_reset("reset3");
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 2'(i), 32'h400 + 32'(i), 1'b0);
    expect_out("midrst.pre", 1'b1, 2'd0, 2'd0, 32'h400);
    check("midrst.pre_afull", 32'(bus.fifo_almost_full), 32'd1);
    @(negedge clk);
    bus.resp_push = 1'b0;
    rst_b = 1'b0;
    #1;
    expect_zero_outputs("midrst.during");
    @(negedge clk);
    rst_b = 1'b1;
    step(1'b1, 2'd2, 2'd3, 32'h500, 1'b0);
    expect_out("midrst.new", 1'b1, 2'd2, 2'd3, 32'h500);
    check("midrst.new_afull", 32'(bus.fifo_almost_full), 32'd0);
    step(1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    expect_out("midrst.drained", 1'b0, 2'd0, 2'd0, 32'h0);
    check("midrst.sent", 32'(bus.sent_count), 32'd1);
    step(1'b0, 2'd0, 2'd0, 32'h0, 1'b1);
    expect_out("midrst.nostale", 1'b0, 2'd0, 2'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/resp_out_fifo.md
# resp_out_fifo

Response-side transmitter that returns completed results to the requester. It buffers response packets produced by the execution units in a DEPTH-entry circular FIFO and presents them through a single registered output stage. The output uses a valid/ready handshake. The block also reports back-pressure, a sticky overflow error and a count of delivered responses.

## Interface
- DEPTH, 4, number of FIFO storage entries; must be a power of two and at least 2.
- ID_W, 2, response tag width; matches the request id width.
- RESP_W, 2, response code width.
- DATA_W, 32, response data width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- resp_push  in  1  write strobe; the response on resp_in_* is offered this cycle.
- resp_in_id  in  ID_W  tag of the offered response.
- resp_in_code  in  RESP_W  response code of the offered response.
- resp_in_data  in  DATA_W  result data of the offered response.
- fifo_full  out  1  high when the storage count equals DEPTH.
- fifo_almost_full  out  1  high when the storage count is at least DEPTH-1.
- out_valid  out  1  the output stage holds a response.
- out_ready  in  1  downstream accepts the response this cycle.
- out_id  out  ID_W  tag of the response in the output stage.
- out_code  out  RESP_W  response code of the response in the output stage.
- out_data  out  DATA_W  result data of the response in the output stage.
- overflow_err  out  1  sticky; a push was dropped.
- sent_count  out  16  number of completed output handshakes, modulo 2^16.

## Operation
- Storage:
  - DEPTH-entry memory with PTR_WIDTH=$clog2(DEPTH) read and write pointers, plus a count of PTR_WIDTH+1 bits.
  - Pointers wrap naturally from DEPTH-1 to 0.
- Output stage FSM, two states:
  - OUT_EMPTY: out_valid=0.
  - OUT_VALID: out_valid=1.
- Definitions:
  - handshake = out_valid && out_ready.
  - stage_free = OUT_EMPTY || handshake.
- Load rule, evaluated every cycle:
  - If stage_free and count>0: the head entry moves into the output stage, rd_ptr increments and count decrements. The FSM ends in OUT_VALID.
  - If stage_free, count==0 and resp_push: bypass. resp_in_* loads directly into the output stage and memory is not written. The FSM ends in OUT_VALID.
  - If stage_free and nothing is available: the FSM goes to OUT_EMPTY.
  - In OUT_VALID with out_ready=0: out_id, out_code and out_data hold stable. out_valid must not drop.
- Push rule:
  - A push that is not bypassed writes memory at wr_ptr and increments wr_ptr.
  - It is accepted when count<DEPTH, or when count==DEPTH and a head pop happens in the same cycle.
  - A simultaneous push and pop leaves count unchanged.
  - Write and read in the same cycle at count==DEPTH: read takes the old head, and the write lands in the slot just freed.
- Overflow:
  - A push at count==DEPTH with no same-cycle pop is dropped. Memory, wr_ptr and count are unchanged.
  - overflow_err sets the following cycle and stays high until reset.
- While out_valid=0, out_id, out_code and out_data are driven to 0.
- sent_count increments by 1 on every handshake and wraps from 0xFFFF to 0.
- fifo_full and fifo_almost_full are combinational from count. They do not include the output stage.

## Timing
- On rst_b low, asynchronously:
  - pointers, count, memory and output stage cleared;
  - FSM in OUT_EMPTY;
  - out_valid=0, out_id/out_code/out_data=0, fifo_full=0, fifo_almost_full=0, overflow_err=0, sent_count=0.
- Reset asserted mid-operation discards all buffered and staged responses. No handshake completes in the reset cycle.
- Latency:
  - Push into an empty block at edge N: out_valid=1 after edge N, so visible in cycle N+1.
  - Push behind existing entries: the response reaches the output stage in the cycle after the preceding response's handshake.
- Throughput: one response per cycle while out_ready=1 and data is available. There are no bubbles between back-to-back entries.
- Total capacity: DEPTH+1 responses (memory plus output stage).

## Test plan
- Reset, then push id=1, code=0, data=0x0000_00AA at cycle 0 with out_ready=1. Required: out_valid=1 in cycle 1 with id=1 and data=0xAA; sent_count=1 after cycle 1.
- Hold out_ready=0 and push 5 responses with ids 0,1,2,3,0 (DEPTH=4). Required: the first is in the output stage. fifo_almost_full=1 after the 4th push, fifo_full=1 after the 5th. out_* stays stable throughout.
- From the full state, push a 6th response with out_ready=0. Required: it is dropped, overflow_err=1 from the next cycle and sticky, count stays 4. Then raise out_ready. Required: exactly 5 responses drain in order on consecutive cycles, with sent_count=5.
- From the full state, push and set out_ready=1 in the same cycle. Required: the push is accepted, count stays 4 and overflow_err stays 0. Drain order preserves the new entry last.
- Stream 20 responses with out_ready=1, so the pointers wrap several times. Required: ids and data come out in push order with one per cycle and no gaps.
- Assert rst_b low while 3 entries are queued and out_valid=1. Required: all outputs are 0 immediately. After release, a new push appears alone with no stale data.
